// File: rtl/btn_input_pkg.sv
// Shared types and helpers for the push-button receive path.
package btn_input_pkg;

    localparam int EVT_W = 8;
    localparam logic EVT_PRESS = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    typedef struct packed {
        logic       press;
        logic [2:0] rsvd;
        logic [3:0] idx;
    } evt_t;

    function automatic int btn_cnt_w(input int d);
        return $clog2(d);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, debounce counter and accepted state.
module btn_debounce
    import btn_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic state_o,
    output logic change_o
);

    localparam int CNT_W = btn_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             change_s;

    // High in the cycle whose closing edge accepts the new level, so the
    // parent can latch the event on the same edge that updates state_o.
    assign change_s = (sync2_r != state_r) && (cnt_r == CNT_LAST);

    // Synchronizer, debounce counter and accepted state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            state_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= btn_i;
            sync2_r <= sync1_r;
            if (sync2_r == state_r) begin
                cnt_r <= '0;
            end else if (change_s) begin
                state_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign state_o  = state_r;
    assign change_o = change_s;

endmodule

// File: rtl/btn_input_ctrl.sv
// Debounced push-button inputs with a press/release event FIFO (FWFT),
// lowest-index-first arbitration, sticky overflow and an interrupt line.
module btn_input_ctrl
    import btn_input_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             en_i,
    output logic [N_BTN-1:0] btn_state_o,
    output logic             evt_valid_o,
    output logic [EVT_W-1:0] evt_data_o,
    input  logic             evt_ready_i,
    output logic             overflow_o,
    input  logic             clr_overflow_i,
    output logic             irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    logic [N_BTN-1:0]  state_s;
    logic [N_BTN-1:0]  change_s;
    logic [N_BTN-1:0]  fire_s;
    logic [N_BTN-1:0]  served_s;
    logic [N_BTN-1:0]  pending_r;
    logic [N_BTN-1:0]  press_r;
    logic              push_req_s;
    logic [3:0]        sel_idx_s;
    logic              sel_press_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              ovw_s;
    logic              full_s;
    logic              evt_valid_s;
    evt_t              push_evt_s;
    evt_t              mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [FCNT_W-1:0] fifo_cnt_r;
    logic              ovf_r;
    logic              irq_r;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn_i[g]),
            .state_o (state_s[g]),
            .change_o(change_s[g])
        );
    end

    assign fire_s      = change_s & {N_BTN{en_i}};
    assign evt_valid_s = (fifo_cnt_r != '0);
    assign full_s      = (fifo_cnt_r == FIFO_FULL);
    assign pop_s       = evt_valid_s & evt_ready_i;

    // Lowest-index pending channel wins; scanning downward leaves it last.
    always_comb begin
        push_req_s  = 1'b0;
        sel_idx_s   = 4'd0;
        sel_press_s = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_r[i]) begin
                push_req_s  = 1'b1;
                sel_idx_s   = 4'(i);
                sel_press_s = press_r[i];
            end else begin
                push_req_s = push_req_s;
            end
        end
        served_s   = N_BTN'(push_req_s) << sel_idx_s;
        push_s     = push_req_s & (~full_s | pop_s);
        drop_s     = push_req_s & full_s & ~pop_s;
        ovw_s      = |(fire_s & pending_r & ~served_s);
        push_evt_s = '{press: sel_press_s ? EVT_PRESS : EVT_RELEASE,
                       rsvd: 3'b000, idx: sel_idx_s};
    end

    // Pending flags, FIFO storage/pointers, overflow and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r  <= '0;
            press_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            ovf_r      <= 1'b0;
            irq_r      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            pending_r <= (pending_r & ~served_s) | fire_s;
            // A firing channel always flips, so the new level is ~state.
            press_r   <= (press_r & ~fire_s) | (~state_s & fire_s);
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_evt_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FCNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FCNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (drop_s || ovw_s) begin
                ovf_r <= 1'b1;
            end else if (clr_overflow_i) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            irq_r <= evt_valid_s | ovf_r;
        end
    end

    assign btn_state_o = state_s;
    assign evt_valid_o = evt_valid_s;
    assign evt_data_o  = evt_valid_s ? mem_r[rd_ptr_r] : '0;
    assign overflow_o  = ovf_r;
    assign irq_o       = irq_r;

endmodule

// File: doc/btn_input_ctrl.md
Name: btn_input_ctrl

Overview:
- Receive side of the board push-button interface: takes the asynchronous btn[3:0] pins that the SoC bench drives and turns them into clean, software-visible events.
- Per channel: 2-FF synchronizer, then a debounce counter, then a stable state register.
- Press/release events are queued in a small first-word-fall-through (FWFT) event FIFO, read by the peripherals unit through a valid/ready pop port; irq_o flags pending work.
- Sits in the SoC peripherals, beside the LED output register.

Parameters:
- N_BTN, 4, number of button channels (1..16).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles before a state change is accepted (1 ms at 50 MHz); minimum 2.
- FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_i  input  N_BTN  raw asynchronous button pins, 1 = pressed.
- en_i  input  1  event generation enable.
- btn_state_o  output  N_BTN  debounced button state.
- evt_valid_o  output  1  FIFO head valid.
- evt_data_o  output  8  head event: [7] 1 = press, 0 = release; [6:4] = 0; [3:0] = channel index.
- evt_ready_i  input  1  pop the head when evt_valid_o is high.
- overflow_o  output  1  sticky flag: an event was lost.
- clr_overflow_i  input  1  clears overflow_o.
- irq_o  output  1  registered, equals evt_valid_o | overflow_o.

Behaviour:
- Reset (rst high at a rising clk edge): sync FFs, counters, btn_state_o, pending flags, FIFO pointers/count, overflow_o and irq_o all go to 0. evt_valid_o = 0 and evt_data_o = 0x00.
- Reset mid-debounce discards any partial count. A button held through reset produces a press event D+2 edges after rst falls.
- Synchronizer: btn_sync = btn_i delayed by 2 edges.
- Debounce, per channel, each edge (D = DEBOUNCE_CYCLES):
  - btn_sync == state: cnt <= 0.
  - btn_sync != state and cnt == D-1: state <= btn_sync, cnt <= 0, event fires.
  - otherwise: cnt <= cnt+1.
- Debounce consequences:
  - A stable input change appears on btn_state_o at the (D+2)th rising edge after btn_i changes.
  - Any bounce back to the old value restarts the count.
  - cnt width is $clog2(D).
- Event fire: if en_i = 1, set pending[i] and latch the press/release bit.
  - If pending[i] is already set: overwrite it and set overflow_o.
  - If en_i = 0: btn_state_o still updates and no event is generated.
- Arbiter: each cycle, the lowest-index pending channel is pushed.
  - Push is allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - If full and no pop: the entry is dropped and overflow_o set.
  - pending[i] clears on push or drop.
  - One push per cycle maximum.
- FIFO (FWFT):
  - evt_valid_o = (count != 0); evt_data_o = head entry.
  - Pop on evt_valid_o & evt_ready_i.
  - evt_ready_i with an empty FIFO is ignored.
  - Simultaneous push+pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
- Latency: the edge that updates btn_state_o sets pending; the push happens on the next edge; evt_valid_o is high one cycle after btn_state_o changes (when the FIFO was empty).
- overflow_o:
  - Set on any drop or overwrite.
  - Cleared by clr_overflow_i.
  - A set and a clear in the same cycle: set wins.
- irq_o: registered, equals evt_valid_o | overflow_o, so it is one cycle behind.

Decomposition:
- Package btn_input_pkg:
  - evt_t packed struct {press, rsvd[2:0], idx[3:0]};
  - constants EVT_PRESS = 1'b1, EVT_RELEASE = 1'b0, EVT_W = 8;
  - function btn_cnt_w(D) returning $clog2(D).
- One sub-module, btn_debounce: a single channel with synchronizer, counter and state. Outputs state_o and a one-cycle pulse change_o. Instantiated N_BTN times via generate.
- Arbiter and FIFO stay in btn_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8, N_BTN=4, clk period 20 ns):
1. rst high 2 edges, btn_i=0 for 100 cycles -> btn_state_o=0, evt_valid_o=0, irq_o=0, overflow_o=0.
2. btn_i[0] 0->1 held, en_i=1 -> btn_state_o[0] rises at the 6th edge; evt_valid_o=1 next cycle with evt_data_o=0x80; irq_o one cycle later. One cycle of evt_ready_i -> evt_valid_o=0. Release -> 0x00.
3. btn_i[1] high for 3 cycles then low (bounce) -> btn_state_o[1] stays 0, no event. High for 4+2 cycles -> 0x81.
4. btn_i[2] and btn_i[3] rise in the same cycle -> both states rise on the same edge; FIFO delivers 0x82 then 0x83 on consecutive pops.
5. 9 distinct debounced events, evt_ready_i=0 -> 8 entries held (count full), 9th dropped, overflow_o=1, irq_o=1. Drain 8 pops, pulse clr_overflow_i -> overflow_o=0, irq_o=0.
6. en_i=0, press btn_i[0] -> btn_state_o[0]=1, no event. rst asserted 2 cycles into a debounce of btn_i[3] then released with btn_i[3] held -> press 0x83 arrives D+2 edges after rst falls.
